// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, 5x oversampled, LSB-first.
//
// Runs on the prescaler's 5x-baud clock. The raw rx pin is synchronized through
// two flops, frames are recovered with a per-bit phase counter, and each good
// byte is offered to the consumer through a valid/ack handshake.
//
// Optional build macro: UART_MAJORITY_EN
//   defined   : each bit is the 2-of-3 majority of the samples at phases 1,2,3,
//               decided at phase 3 (one cycle more latency).
//   undefined : single sample at phase 2.
//
// Ports:
//   clk      in   5x-baud clock
//   rst      in   synchronous, active-high reset
//   rx       in   raw asynchronous serial input, idle high
//   data     out  received byte, held stable while valid=1
//   valid    out  byte available
//   ack      in   consumer takes the byte
//   overrun  out  sticky: a byte was lost, cleared by ack
//   ferr     out  one-cycle pulse: stop bit sampled low
//   brk      out  one-cycle pulse: break (all-zero frame with low stop bit)
module uart_rx #(
  parameter int OVERSAMPLE = 5,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 overrun,
  output logic                 ferr,
  output logic                 brk
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [2:0]       PH_LAST  = 3'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } state_t;

  state_t               state, state_d;
  logic                 rx_p0, rx_s;
  logic [2:0]           phase, phase_d;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_p1;
  logic                 bit_val;
  logic                 shift_en;
  logic                 stop_eval;

`ifdef UART_MAJORITY_EN
  localparam logic [2:0] PH_DEC = 3'd3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic samp1_p0, samp2_p0;

  // Capture the early samples; the third one is rx_s itself at phase 3.
  always_ff @(posedge clk) begin
    if (phase == 3'd1) samp1_p0 <= rx_s;
    if (phase == 3'd2) samp2_p0 <= rx_s;
  end

  assign bit_val = maj3(samp1_p0, samp2_p0, rx_s);
`else
  localparam logic [2:0] PH_DEC = 3'd2;

  assign bit_val = rx_s;
`endif

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d   = state;
    shift_en  = 1'b0;
    stop_eval = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (phase == PH_DEC && bit_val) state_d = IDLE;
        else if (phase == PH_LAST)      state_d = DATA;
      end
      DATA: begin
        if (phase == PH_DEC) shift_en = 1'b1;
        if (phase == PH_LAST && bit_idx == IDX_LAST) state_d = STOP;
      end
      STOP: begin
        if (phase == PH_DEC) begin
          stop_eval = 1'b1;
          // A break leaves the line low; wait for it to rise before re-arming.
          if (!bit_val && shift_p1 == '0) state_d = BRK_WAIT;
          else                             state_d = IDLE;
        end
      end
      BRK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase runs only inside a frame and restarts at 0 whenever a frame begins.
  always_comb begin
    phase_d = 3'd0;
    if (state != IDLE && state != BRK_WAIT &&
        state_d != IDLE && state_d != BRK_WAIT) begin
      phase_d = (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
    end
  end

  // Stage p0: synchronizer, FSM and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      phase   <= 3'd0;
      bit_idx <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      ferr    <= 1'b0;
      brk     <= 1'b0;
      data    <= '0;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
      state <= state_d;
      phase <= phase_d;

      if (state == START)                          bit_idx <= '0;
      else if (state == DATA && phase == PH_LAST)  bit_idx <= bit_idx + 1'b1;

      ferr <= 1'b0;
      brk  <= 1'b0;

      if (valid && ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end

      // Stop-bit decision; a simultaneous ack frees the slot for the new byte.
      if (stop_eval) begin
        if (bit_val) begin
          if (!valid || ack) begin
            data    <= shift_p1;
            valid   <= 1'b1;
            overrun <= 1'b0;
          end else begin
            overrun <= 1'b1;
          end
        end else if (shift_p1 == '0) begin
          brk <= 1'b1;
        end else begin
          ferr <= 1'b1;
        end
      end
    end
  end

  // Stage p1: data shift register, LSB arrives first so shift toward bit 0.
  always_ff @(posedge clk) begin
    if (shift_en) shift_p1 <= {bit_val, shift_p1[DATA_BITS-1:1]};
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int OS = 5;
`ifdef UART_MAJORITY_EN
  localparam int LAT = 52;
`else
  localparam int LAT = 51;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       valid, overrun, ferr, brk;

  uart_rx #(.OVERSAMPLE(5), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .ack(ack), .overrun(overrun), .ferr(ferr), .brk(brk)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         t;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ferr_cnt = 0;
  int   brk_cnt = 0;
  int   rise_cnt = 0;
  logic valid_prev = 1'b0;
  logic auto_ack = 1'b0;
  int   ack_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: count flag pulses and check each new byte against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (ferr) ferr_cnt++;
      if (brk)  brk_cnt++;
      if (valid && !valid_prev) begin
        rise_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", int'(data), int'(e.d));
          chk("latency", cyc - e.t, LAT);
        end
      end
    end
    valid_prev = valid;
  end

  // Consumer: automatic ack 5 cycles after valid, or one ack on request.
  initial begin
    logic a_prev;
    logic rise;
    int   ack_done;
    a_prev   = 1'b0;
    ack_done = 0;
    ack      = 1'b0;
    forever begin
      @(negedge clk);
      rise   = valid && !a_prev;
      a_prev = valid;
      if (auto_ack && rise) begin
        repeat (5) @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        chk("ack_clears_valid", int'(valid), 0);
        chk("ack_overrun", int'(overrun), 0);
        a_prev = valid;
      end else if (ack_req != ack_done) begin
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        ack_done++;
      end
    end
  end

  // Stimulus runs #1 after a posedge, so cyc equals the edge index.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic push);
    exp_t e;
    e.d = b;
    e.t = cyc;
    if (push) q.push_back(e);
    rx = 1'b0;
    tick(OS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(OS);
    end
    rx = stop;
    tick(OS);
  endtask

  // One corrupted sample per data bit, rotating over offsets 2,3,4 of the bit,
  // which are the three cycles sampled at phases 1,2,3.
  task automatic send_glitch(input logic [7:0] b);
    exp_t e;
    e.d = b;
    e.t = cyc;
    q.push_back(e);
    rx = 1'b0;
    tick(OS);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < OS; c++) begin
        rx = (c == 2 + (i % 3)) ? ~b[i] : b[i];
        tick(1);
      end
    end
    rx = 1'b1;
    tick(OS);
  endtask

  initial begin
    int f0, b0, r0, w;
    rx  = 1'b1;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ferr", int'(ferr), 0);
    chk("rst_brk", int'(brk), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(10);

    // Single byte, acked.
    auto_ack = 1'b1;
    send(8'hA5, 1'b1, 1'b1);
    idle(20);
    chk("a5_ferr", ferr_cnt, 0);
    chk("a5_brk", brk_cnt, 0);
    chk("a5_overrun", int'(overrun), 0);

    // Back-to-back frames with no idle gap.
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    idle(20);
    chk("b2b_rises", rise_cnt, 3);
    chk("b2b_flags", ferr_cnt + brk_cnt, 0);

    // Overrun: second byte while the first is still pending.
    auto_ack = 1'b0;
    send(8'h3C, 1'b1, 1'b1);
    idle(5);
    chk("ovr_before", int'(overrun), 0);
    send(8'hC3, 1'b1, 1'b0);
    idle(10);
    chk("ovr_valid", int'(valid), 1);
    chk("ovr_data_kept", int'(data), 8'h3C);
    chk("ovr_flag", int'(overrun), 1);
    ack_req++;
    idle(5);
    chk("ovr_ack_valid", int'(valid), 0);
    chk("ovr_ack_flag", int'(overrun), 0);
    auto_ack = 1'b1;

    // Framing error, then a good frame.
    f0 = ferr_cnt;
    r0 = rise_cnt;
    send(8'h55, 1'b0, 1'b0);
    idle(20);
    chk("ferr_pulse", ferr_cnt - f0, 1);
    chk("ferr_no_byte", rise_cnt - r0, 0);
    chk("ferr_valid", int'(valid), 0);
    send(8'h12, 1'b1, 1'b1);
    idle(20);

    // Break: line low for 100 cycles.
    f0 = ferr_cnt;
    b0 = brk_cnt;
    r0 = rise_cnt;
    rx = 1'b0;
    tick(100);
    idle(20);
    chk("brk_pulse", brk_cnt - b0, 1);
    chk("brk_no_ferr", ferr_cnt - f0, 0);
    chk("brk_no_byte", rise_cnt - r0, 0);
    send(8'h7E, 1'b1, 1'b1);
    idle(20);

    // Two-cycle low glitch: false start.
    f0 = ferr_cnt + brk_cnt;
    r0 = rise_cnt;
    rx = 1'b0;
    tick(2);
    idle(60);
    chk("glitch_flags", ferr_cnt + brk_cnt - f0, 0);
    chk("glitch_no_byte", rise_cnt - r0, 0);
    chk("glitch_valid", int'(valid), 0);
    chk("glitch_overrun", int'(overrun), 0);

`ifdef UART_MAJORITY_EN
    send_glitch(8'h96);
    idle(20);
`endif

    w = 0;
    while (q.size() != 0 && w < 200) begin
      tick(1);
      w++;
    end
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
